morph_stream_3x3: RTL and testbench
===================================

Name: morph_stream_3x3

Overview:
- Streaming 3x3 morphological engine for the LCD pixel path. It sits between the picture ROM/line-fetch logic and the display mux.
- Runtime-selectable mode: dilate, erode, open or close. The two stages are internal and cascaded.
- Parametrised in image size and channel width/count.
- Border pixels are replicate-padded, so the output frame is the same size as the input frame. No 2-pixel shrink per stage.

Parameters:
- CH_W, 8, bits per colour channel
- CH_N, 3, channels per pixel; pixel width = CH_W*CH_N
- IMG_W, 250, pixels per line (3..2047)
- IMG_H, 250, lines per frame (3..2047)
- THRESH, 128, binarisation threshold per channel (used only with MORPH_THRESH_EN)

Ports:
- lcd_pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  00 dilate, 01 erode, 10 open (erode then dilate), 11 close (dilate then erode)
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts a pixel when in_valid&&in_ready
- in_data  in  CH_W*CH_N  raster-order input pixel
- in_sof  in  1  marks first pixel of frame, qualified by in_valid
- out_valid  out  1  output pixel valid; no backpressure
- out_data  out  CH_W*CH_N  processed pixel
- out_sof  out  1  with first output pixel
- out_eof  out  1  with last output pixel
- busy  out  1  frame in progress (sof accepted until eof emitted)
- err  out  1  sticky: in_valid high while in_ready low, or in_sof missing/misplaced

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sof=0, out_eof=0, busy=0, err=0. All FSMs return to IDLE and all counters are cleared.
- Top FSM has states IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM on an accepted pixel with in_sof.
  - STREAM -> DRAIN after the IMG_W*IMG_H-th pixel is accepted.
  - DRAIN -> DONE when out_eof is emitted.
  - DONE -> IDLE on the next cycle.
- Mode capture: mode is sampled only on the accepted sof pixel. Changes mid-frame are ignored.
- in_ready is 1 in IDLE and STREAM, and 0 in DRAIN and DONE.
- Pixels accepted in IDLE without in_sof are dropped and set err.
- Stage structure:
  - Each stage has two line buffers of IMG_W pixels, a 3x3 window and x/y counters.
  - Element-wise operation per channel: max for dilate, min for erode.
  - Stage 2 operates only in modes 10 and 11. In modes 00 and 01 it is bypassed and output comes from stage 1.
- Borders: window taps outside the image take the nearest in-image pixel (replicate). Row 0 uses row 0 for the upper tap; column W-1 uses column W-1 for the right tap.
- Timing:
  - A stage emits output (x,y) one cycle after its input (min(x+1,W-1), min(y+1,H-1)) is available, plus 2 register stages.
  - Stage latency is therefore IMG_W+3 cycles in steady state.
  - The stage handles the end-of-line right tap internally with no extra input.
- Drain: after the last input, each stage self-generates the remaining outputs (last line plus 1 pixel) at 1 pixel/clock using replicate data.
- Frame size: exactly IMG_W*IMG_H outputs per frame.
  - out_sof on output #1 only; out_eof on output #IMG_W*IMG_H only.
  - One-line frames are not supported.
- Input gaps: in_valid may drop at any time in STREAM. Stages advance only on valid data and out_valid gaps follow the input gaps.
- Arithmetic: unsigned per-channel compare. No widening; output width equals input width.
- Reset mid-frame returns all state to reset values and discards partial line-buffer contents. The next sof starts a clean frame, with no stale rows used.
- An sof accepted during STREAM sets err and is treated as a normal pixel.

Optional Feature:
- Macro: MORPH_THRESH_EN.
- When defined: each input channel is binarised before stage 1 to all-ones if >= THRESH, else 0. This adds 1 cycle of latency; out timing shifts by 1 cycle.
- When undefined: channels pass raw to stage 1 (grey-scale min/max) and there is no extra latency.

Test Plan:
1. Reset: hold rst_n=0 -> in_ready=1, out_valid=0, out_data=0, busy=0, err=0. Release, send no pixels -> outputs stay idle.
2. Dilate (IMG_W=8, IMG_H=6, mode=00): frame 0x000000 with one 0xFFFFFF at (3,2) -> 48 outputs; 0xFFFFFF exactly at x=2..4, y=1..3; all others 0; out_sof on #1, out_eof on #48.
3. Erode (mode=01): same frame -> all 48 outputs 0. All-0xFFFFFF frame -> all 0xFFFFFF, corners included (replicate border).
4. Close (mode=11): white frame with single black pixel at (4,3) -> all 48 outputs 0xFFFFFF. Open (mode=10) on the isolated white pixel -> all 0.
5. Handshake: after pixel #48, in_ready=0 until out_eof. Drive in_valid during drain -> err=1 and sticky; mode changed mid-frame from 00 to 01 -> frame still processed as dilate.
6. Reset after 20 pixels: then a full new frame of constant 0x404040 in erode mode -> 48 outputs of 0x404040 and no stale data.

Source files
------------

// File: rtl/morph_stream_3x3_if.sv
// Pixel stream bundle for morph_stream_3x3: input stream with ready, output stream without backpressure.
// master = pixel source / sink side, slave = the morphology engine.
interface morph_stream_3x3_if #(
  parameter int PIX_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_data;
  logic             in_sof;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_sof;
  logic             out_eof;

  modport master (
    output in_valid, in_data, in_sof,
    input  in_ready, out_valid, out_data, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output in_ready, out_valid, out_data, out_sof, out_eof
  );
endinterface

// File: rtl/morph_stream_3x3.sv
// Streaming 3x3 morphology (dilate / erode / open / close) with replicate-padded borders.
// Two cascaded stages; the second one runs only for open/close.
// Optional macro MORPH_THRESH_EN: binarise each channel against THRESH before stage 1 (+1 cycle).

// One morphology stage. Slot j (real pixel or self-generated drain slot) emits output j-IMG_W-1.
// A slot at column c builds the column vector centred one row up; the window holds the last two
// columns, so output column c-1 is formed from (w1, w0, new column). Column 0 slots instead flush
// the right-edge pixel of the previous row from (w1, w0, w0).
module morph_stage #(
  parameter int CH_W  = 8,
  parameter int CH_N  = 3,
  parameter int IMG_W = 250,
  parameter int IMG_H = 250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 is_max,
  input  logic                 in_valid,
  input  logic [CH_W*CH_N-1:0] in_data,
  output logic                 out_valid,
  output logic [CH_W*CH_N-1:0] out_data
);
  localparam int PIX_W = CH_W * CH_N;
  localparam int COL_W = 3 * PIX_W;
  localparam int CW    = 12;
  localparam int XW    = $clog2(IMG_W);
  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_H    = CW'(IMG_H);
  localparam logic [CW-1:0] Y_H1   = CW'(IMG_H + 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] TWO    = CW'(2);

  function automatic logic [PIX_W-1:0] pick(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic take_max);
    logic [PIX_W-1:0] r;
    logic [CH_W-1:0]  ca, cb;
    r = '0;
    for (int c = 0; c < CH_N; c++) begin
      ca = a[c*CH_W +: CH_W];
      cb = b[c*CH_W +: CH_W];
      r[c*CH_W +: CH_W] = ((ca > cb) == take_max) ? ca : cb;
    end
    return r;
  endfunction

  logic [PIX_W-1:0] lb_a [IMG_W];  // row y-1
  logic [PIX_W-1:0] lb_b [IMG_W];  // row y-2

  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic [XW-1:0]    col_idx;
  logic             draining, slot, wr_en;
  logic [PIX_W-1:0] tap_top, tap_mid, tap_bot;

  logic             v_valid_q, v_valid_d, v_emit_q, v_emit_d;
  logic             v_tail_q, v_tail_d, v_lcl_q, v_lcl_d;
  logic [COL_W-1:0] v_col_q, v_col_d, w0_q, w0_d, w1_q, w1_d;
  logic             o_valid_q, o_valid_d;
  logic [PIX_W-1:0] o_data_q, o_data_d;

  logic [COL_W-1:0]   col_l, col_r;
  logic [3*COL_W-1:0] win;
  logic [PIX_W-1:0]   res;

  // y_q >= IMG_H means the real pixels are done and the stage clocks itself through the drain
  assign draining = (y_q >= Y_H);
  assign slot     = draining || in_valid;
  assign wr_en    = in_valid && !draining;
  assign col_idx  = x_q[XW-1:0];
  assign tap_mid  = lb_a[col_idx];
  assign tap_top  = (y_q == ONE) ? tap_mid : lb_b[col_idx];
  assign tap_bot  = draining ? tap_mid : in_data;

  // Raster position of the next slot and the registered column vector it produces
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    v_valid_d = slot;
    v_col_d   = {tap_top, tap_mid, tap_bot};
    v_emit_d  = slot && ((x_q == '0) ? (y_q >= TWO) : (y_q >= ONE));
    v_tail_d  = (x_q == '0);
    v_lcl_d   = (x_q == ONE);
    if (slot) begin
      if (y_q == Y_H1) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  // Window assembly with left/right replicate, 9-tap min/max, window shift
  always_comb begin
    col_l = w1_q;
    col_r = v_col_q;
    if (v_tail_q) begin
      col_r = w0_q;
    end else if (v_lcl_q) begin
      col_l = w0_q;
    end
    win = {col_l, w0_q, col_r};
    res = win[PIX_W-1:0];
    for (int i = 1; i < 9; i++) begin
      res = pick(res, win[i*PIX_W +: PIX_W], is_max);
    end
    w0_d      = v_valid_q ? v_col_q : w0_q;
    w1_d      = v_valid_q ? w0_q : w1_q;
    o_valid_d = v_valid_q && v_emit_q;
    o_data_d  = o_valid_d ? res : o_data_q;
  end

  // Line buffers: shift the column down one row on every real pixel
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb_b[col_idx] <= lb_a[col_idx];
      lb_a[col_idx] <= in_data;
    end
  end

  // Stage state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      v_valid_q <= 1'b0;
      v_emit_q  <= 1'b0;
      v_tail_q  <= 1'b0;
      v_lcl_q   <= 1'b0;
      v_col_q   <= '0;
      w0_q      <= '0;
      w1_q      <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      v_valid_q <= v_valid_d;
      v_emit_q  <= v_emit_d;
      v_tail_q  <= v_tail_d;
      v_lcl_q   <= v_lcl_d;
      v_col_q   <= v_col_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign out_valid = o_valid_q;
  assign out_data  = o_data_q;
endmodule

// Top FSM states
//   IDLE   | waiting for an accepted sof pixel
//   STREAM | accepting the frame's IMG_W*IMG_H pixels
//   DRAIN  | input closed, stages flushing the last line
//   DONE   | eof emitted, one cycle before returning to IDLE
module morph_stream_3x3 #(
  parameter int CH_W   = 8,
  parameter int CH_N   = 3,
  parameter int IMG_W  = 250,
  parameter int IMG_H  = 250,
  parameter int THRESH = 128
) (
  input  logic                 lcd_pclk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  morph_stream_3x3_if.slave    bus,
  output logic                 busy,
  output logic                 err
);
  localparam int PIX_W = CH_W * CH_N;
  localparam int CNT_W = 23;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(IMG_W * IMG_H - 1);

  if (IMG_W < 3 || IMG_W > 2047 || IMG_H < 3 || IMG_H > 2047 ||
      THRESH < 0 || THRESH >= (1 << CH_W)) begin : g_param_check
    $error("morph_stream_3x3: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  logic             in_ready, accept, feed;
  logic             st1_in_valid, st1_out_valid, st2_in_valid, st2_out_valid;
  logic [PIX_W-1:0] st1_in_data, st1_out_data, st2_out_data;
  logic             st1_max, st2_max, use_st2, sel_valid;
  logic [PIX_W-1:0] sel_data;

  assign in_ready = (state_q == IDLE) || (state_q == STREAM);
  assign accept   = bus.in_valid && in_ready;
  assign feed     = accept && ((state_q == STREAM) || bus.in_sof);

  // Frame sequencing, mode capture and sticky protocol error
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    in_cnt_d = in_cnt_q;
    err_d    = err_q;
    if (bus.in_valid && !in_ready) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_sof) begin
            state_d  = STREAM;
            mode_d   = mode;
            in_cnt_d = CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          if (bus.in_sof) err_d = 1'b1;
          if (in_cnt_q == PIX_LAST) begin
            state_d  = DRAIN;
            in_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN:   if (out_eof_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and control registers
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      in_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      in_cnt_q <= in_cnt_d;
      err_q    <= err_d;
    end
  end

`ifdef MORPH_THRESH_EN
  logic             th_valid_q, th_valid_d;
  logic [PIX_W-1:0] th_data_q, th_data_d;

  // Per-channel binarisation ahead of stage 1
  always_comb begin
    th_valid_d = feed;
    th_data_d  = th_data_q;
    if (feed) begin
      for (int c = 0; c < CH_N; c++) begin
        th_data_d[c*CH_W +: CH_W] = (bus.in_data[c*CH_W +: CH_W] >= CH_W'(THRESH)) ?
                                    {CH_W{1'b1}} : {CH_W{1'b0}};
      end
    end
  end

  // Binarised pixel register
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      th_valid_q <= 1'b0;
      th_data_q  <= '0;
    end else begin
      th_valid_q <= th_valid_d;
      th_data_q  <= th_data_d;
    end
  end

  assign st1_in_valid = th_valid_q;
  assign st1_in_data  = th_data_q;
`else
  assign st1_in_valid = feed;
  assign st1_in_data  = bus.in_data;
`endif

  // dilate first for 00 and close, erode first for 01 and open
  assign st1_max      = (mode_q == 2'b00) || (mode_q == 2'b11);
  assign st2_max      = (mode_q == 2'b10);
  assign use_st2      = mode_q[1];
  assign st2_in_valid = use_st2 && st1_out_valid;

  morph_stage #(.CH_W(CH_W), .CH_N(CH_N), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_stage1 (
    .clk       (lcd_pclk),
    .rst_n     (rst_n),
    .is_max    (st1_max),
    .in_valid  (st1_in_valid),
    .in_data   (st1_in_data),
    .out_valid (st1_out_valid),
    .out_data  (st1_out_data)
  );

  morph_stage #(.CH_W(CH_W), .CH_N(CH_N), .IMG_W(IMG_W), .IMG_H(IMG_H)) u_stage2 (
    .clk       (lcd_pclk),
    .rst_n     (rst_n),
    .is_max    (st2_max),
    .in_valid  (st2_in_valid),
    .in_data   (st1_out_data),
    .out_valid (st2_out_valid),
    .out_data  (st2_out_data)
  );

  assign sel_valid = use_st2 ? st2_out_valid : st1_out_valid;
  assign sel_data  = use_st2 ? st2_out_data  : st1_out_data;

  // Output framing: count emitted pixels to place sof/eof
  always_comb begin
    out_valid_d = sel_valid;
    out_sof_d   = sel_valid && (out_cnt_q == '0);
    out_eof_d   = sel_valid && (out_cnt_q == PIX_LAST);
    out_data_d  = sel_valid ? sel_data : out_data_q;
    out_cnt_d   = out_cnt_q;
    if (sel_valid) out_cnt_d = out_eof_d ? '0 : out_cnt_q + CNT_W'(1);
  end

  // Output registers
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign busy          = (state_q == STREAM) || (state_q == DRAIN);
  assign err           = err_q;
endmodule

// File: tb/tb_morph_stream_3x3.sv
// Bench for morph_stream_3x3 on an 8x6 frame with a behavioural 2-D reference model.
module tb_morph_stream_3x3;
  localparam int CH_W = 8, CH_N = 3, IMG_W = 8, IMG_H = 6, THRESH = 128;
  localparam int PIX_W = CH_W * CH_N;
  localparam int NPIX  = IMG_W * IMG_H;

  typedef logic [PIX_W-1:0] pix_t;
  typedef struct packed {pix_t d; logic s; logic e;} out_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy, err;
  int         total = 0, bad = 0;
  out_t       outq[$];
  pix_t       fr[4][IMG_H][IMG_W];  // 0 input, 1 pre-processed, 2 first pass, 3 expected

  morph_stream_3x3_if #(.PIX_W(PIX_W)) bus();

  morph_stream_3x3 #(.CH_W(CH_W), .CH_N(CH_N), .IMG_W(IMG_W), .IMG_H(IMG_H), .THRESH(THRESH)) dut (
    .lcd_pclk (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .bus      (bus),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.out_valid) outq.push_back({bus.out_data, bus.out_sof, bus.out_eof});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: each output channel is the max/min over the 3x3 neighbourhood with clamped coordinates
  task automatic morph_pass(input int src, input int dst, input bit is_max);
    int yy, xx;
    logic [CH_W-1:0] best, v;
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        for (int ch = 0; ch < CH_N; ch++) begin
          best = is_max ? '0 : '1;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              yy = (y + dy < 0) ? 0 : (y + dy > IMG_H - 1) ? IMG_H - 1 : y + dy;
              xx = (x + dx < 0) ? 0 : (x + dx > IMG_W - 1) ? IMG_W - 1 : x + dx;
              v = fr[src][yy][xx][ch*CH_W +: CH_W];
              if (is_max ? (v > best) : (v < best)) best = v;
            end
          fr[dst][y][x][ch*CH_W +: CH_W] = best;
        end
  endtask

  task automatic build_expected(input logic [1:0] m);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) begin
        fr[1][y][x] = fr[0][y][x];
`ifdef MORPH_THRESH_EN
        for (int ch = 0; ch < CH_N; ch++)
          fr[1][y][x][ch*CH_W +: CH_W] = (fr[0][y][x][ch*CH_W +: CH_W] >= CH_W'(THRESH)) ? '1 : '0;
`endif
      end
    morph_pass(1, 2, (m == 2'b00) || (m == 2'b11));
    if (m[1]) morph_pass(2, 3, m == 2'b10);
    else fr[3] = fr[2];
  endtask

  task automatic fill(input pix_t bg);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) fr[0][y][x] = bg;
  endtask

  task automatic fill_random();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) fr[0][y][x] = PIX_W'($urandom);
  endtask

  task automatic drive_frame(input logic [1:0] m0, input logic [1:0] m1, input int gap_pct, input int npix);
    int t;
    t = 0;
    while (!(bus.in_ready && !busy) && t < 200) begin @(negedge clk); t++; end
    check("ready_before_frame", {31'd0, bus.in_ready && !busy}, 32'd1);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0);
      bus.in_data  = fr[0][i / IMG_W][i % IMG_W];
      mode         = (i == 0) ? m0 : m1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic collect_check(input string tag, input logic [1:0] m);
    int t, n, nsof, neof;
    build_expected(m);
    t = 0;
    while (outq.size() < NPIX && t < 2000) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    check({tag, "_count"}, outq.size(), NPIX);
    n = (outq.size() < NPIX) ? outq.size() : NPIX;
    nsof = 0;
    neof = 0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_px%0d", tag, i), outq[i].d, fr[3][i / IMG_W][i % IMG_W]);
      nsof += outq[i].s;
      neof += outq[i].e;
    end
    if (n > 0) begin
      check({tag, "_sof_first"}, outq[0].s, 1);
      check({tag, "_eof_last"}, outq[n-1].e, 1);
    end
    check({tag, "_sof_count"}, nsof, 1);
    check({tag, "_eof_count"}, neof, 1);
    outq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    outq.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sof", bus.out_sof, 0);
    check("rst_out_eof", bus.out_eof, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_output", outq.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_err", err, 0);

    // dilate of an isolated white pixel
    fill('0);
    fr[0][2][3] = 24'hFFFFFF;
    drive_frame(2'b00, 2'b00, 0, NPIX);
    collect_check("dilate_dot", 2'b00);
    check("dilate_dot_win", fr[3][1][2] & fr[3][3][4] & ~fr[3][0][3] & ~fr[3][2][5], 24'hFFFFFF);

    // erode: dot vanishes, white frame stays white to the corners
    drive_frame(2'b01, 2'b01, 20, NPIX);
    collect_check("erode_dot", 2'b01);
    fill(24'hFFFFFF);
    drive_frame(2'b01, 2'b01, 20, NPIX);
    collect_check("erode_white", 2'b01);

    // close fills a black hole, open removes a white dot
    fill(24'hFFFFFF);
    fr[0][3][4] = '0;
    drive_frame(2'b11, 2'b11, 15, NPIX);
    collect_check("close_hole", 2'b11);
    fill('0);
    fr[0][2][3] = 24'hFFFFFF;
    drive_frame(2'b10, 2'b10, 15, NPIX);
    collect_check("open_dot", 2'b10);
    check("no_err_so_far", err, 0);

    // mode changes after sof are ignored; valid during drain flags err
    fill_random();
    drive_frame(2'b00, 2'b01, 25, NPIX);
    check("drain_in_ready", bus.in_ready, 0);
    check("drain_busy", busy, 1);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("drain_err", err, 1);
    collect_check("mode_hold", 2'b00);
    check("err_sticky", err, 1);
    check("busy_after_frame", busy, 0);

    // pixel without sof in IDLE is dropped and flagged
    do_reset();
    check("err_cleared", err, 0);
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    bus.in_data  = 24'h123456;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("nosof_err", err, 1);
    repeat (20) @(negedge clk);
    check("nosof_dropped", outq.size(), 0);
    check("nosof_busy", busy, 0);

    // reset mid-frame, then a clean constant frame
    do_reset();
    fill_random();
    drive_frame(2'b00, 2'b00, 0, 20);
    do_reset();
    check("midrst_err", err, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    fill(24'h404040);
    drive_frame(2'b01, 2'b01, 10, NPIX);
    collect_check("erode_const", 2'b01);

    // random frames in random modes with input gaps
    for (int k = 0; k < 4; k++) begin
      logic [1:0] m;
      m = 2'($urandom_range(3));
      fill_random();
      drive_frame(m, 2'($urandom_range(3)), 30, NPIX);
      collect_check($sformatf("rand%0d_m%0d", k, m), m);
    end
    check("final_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
